param_conv_controller: RTL and testbench
========================================

PARAM_CONV_CONTROLLER -- requirements
Module: param_conv_controller

Interface
REQ-001 SHALL have parameter FEATURE_MAP_WIDTH, default 128, feature-map columns.
REQ-002 SHALL have parameter FEATURE_MAP_HEIGHT, default 128, feature-map rows.
REQ-003 SHALL have parameter OUTPUT_NB_CHANNELS, default 32, output channels per tile.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3, odd, 1..5.
REQ-005 SHALL have parameter NB_KERNEL_BANKS, default 16, kernel SRAM banks.
REQ-006 SHALL have parameter FEATURE_BEATS, default 6, input beats per tile.
REQ-007 SHALL have parameter OUTS_PER_BEAT, default 3, channels per output beat; OUTPUT_BEATS = ceil(OUTPUT_NB_CHANNELS/OUTS_PER_BEAT).
REQ-008 SHALL have ports: clk in 1 clock; arst_n_in in 1 asynchronous active-low reset.
REQ-009 SHALL have ports: start in 1; abort in 1; conv_stride_mode in 2 (0:1, 1:2, 2:4, 3:reserved); running out 1; cfg_error out 1.
REQ-010 SHALL have ports: bus_valid in 1; bus_ready out 1; output_valid out 1; output_ready in 1; driving_busses out 1.
REQ-011 SHALL have ports: mux_output_select out clog2(OUTPUT_BEATS); output_x out clog2(WIDTH); output_y out clog2(HEIGHT); output_ch out clog2(OUTPUT_NB_CHANNELS).
REQ-012 SHALL have ports: Feature_we, Output_we out 1; mux_next_feature_we_select out clog2(FEATURE_BEATS+1), idle value FEATURE_BEATS.
REQ-013 SHALL have ports: mux9_select, KERNEL_read_addr, KERNEL_write_addr out clog2(K*K); KERNEL_re, product_valid, mac_valid, mac_accumulate_internal out 1; mux_KERNEL_we_select out clog2(NB_KERNEL_BANKS+1), idle value NB_KERNEL_BANKS.

Function
REQ-014 SHALL implement states IDLE, LOAD_KERNEL, LOAD_FEATURE, COMMIT, COMPUTE, DRAIN.
REQ-015 IDLE: running=0; start with mode!=3 latches stride, clears x,y, moves to LOAD_KERNEL; start with mode 3 pulses cfg_error one cycle, stays IDLE.
REQ-016 LOAD_KERNEL: bus_ready=1; each bus_valid&&bus_ready beat writes addr counter (0..K*K-1) into bank counter (0..NB_KERNEL_BANKS-1); after NB_KERNEL_BANKS*K*K beats go LOAD_FEATURE; no beat = no counter advance.
REQ-017 LOAD_FEATURE: bus_ready=1, mux_next_feature_we_select=beat index on accepted beats only; after FEATURE_BEATS beats go COMMIT.
REQ-018 COMMIT (1 cycle): Feature_we=1; Output_we=1 unless first tile; captures previous tile (x,y) into output_x/output_y; then COMPUTE.
REQ-019 COMPUTE runs three counters in parallel: tap 0..K*K-1, one per cycle unconditionally; feature beat (if not last tile) on bus handshake; output beat (if not first tile) on output handshake.
REQ-020 Tap cycle t: product_valid=1, KERNEL_re=1, KERNEL_read_addr=mux9_select=t; mac_valid=1 on cycles 1..K*K; mac_accumulate_internal=0 only on cycle 1.
REQ-021 Output beat b: driving_busses=1, output_valid=1, mux_output_select=b, output_ch=b*OUTS_PER_BEAT; output_valid SHALL hold with stable payload until output_ready.
REQ-022 COMPUTE exits when taps done (incl. mac cycle K*K) AND feature beats done AND output beats done: to COMMIT, or DRAIN after last tile.
REQ-023 Tile order: y inner, x outer; next = +stride; wrap to 0 when coordinate >= dim - stride; last tile = last_x && last_y.
REQ-024 DRAIN: emits OUTPUT_BEATS beats of final tile with handshake, then IDLE.
REQ-025 abort in any non-IDLE state SHALL return to IDLE next cycle, deasserting all strobes; start during non-IDLE ignored.

Reset
REQ-026 arst_n_in low SHALL force IDLE, all counters/x/y/output_x/output_y=0, all strobes 0, select outputs to idle values, mac_accumulate_internal=1.

Structure
REQ-027 State enum, stride decode function, and beat-count constants SHALL live in shared package conv_ctrl_pkg.
REQ-028 Counters SHALL use one sub-module wrap_counter (width, max, enable, clear, last flag).

Verification
REQ-029 K=3, banks=2: 18 beats with bus_valid gaps every other cycle -> 18 KERNEL writes, addr 0..8 per bank, state LOAD_FEATURE after beat 18.
REQ-030 Map 4x4, stride mode 1: exactly 4 tiles, output_x/y sequence (0,0),(0,2),(2,0),(2,2), 4x OUTPUT_BEATS beats total.
REQ-031 output_ready held low 20 cycles mid-COMPUTE -> output_valid and payload stable, no COMMIT until release.
REQ-032 start with mode 3 -> cfg_error one-cycle pulse, running stays 0.
REQ-033 abort during COMPUTE tap 4 -> IDLE next cycle, all strobes 0; new start runs full job correctly.
REQ-034 arst_n_in asserted mid-DRAIN -> immediate IDLE, all outputs at reset values.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the parameterised convolution controller.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KERNEL,
    ST_LOAD_FEATURE,
    ST_COMMIT,
    ST_COMPUTE,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] MODE_RESERVED = 2'd3;

  // Number of output beats needed to carry all channels of one tile.
  function automatic int output_beats(input int channels, input int per_beat);
    return (channels + per_beat - 1) / per_beat;
  endfunction

  function automatic logic [2:0] stride_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter 0..MAX with synchronous clear, wrap on MAX and a last flag.
module wrap_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q, count_d;

  assign last  = (count_q == WIDTH'(MAX));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule

// File: rtl/param_conv_controller.sv
// Tile sequencer for a convolution engine: kernel load, feature load,
// overlapped compute / next-feature load / previous-tile output, final drain.
module param_conv_controller
  import conv_ctrl_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int KERNEL_SIZE        = 3,
  parameter int NB_KERNEL_BANKS    = 16,
  parameter int FEATURE_BEATS      = 6,
  parameter int OUTS_PER_BEAT      = 3
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic start,
  input  logic abort,
  input  logic [1:0] conv_stride_mode,
  output logic running,
  output logic cfg_error,
  input  logic bus_valid,
  output logic bus_ready,
  output logic output_valid,
  input  logic output_ready,
  output logic driving_busses,
  output logic [$clog2(output_beats(OUTPUT_NB_CHANNELS, OUTS_PER_BEAT))-1:0] mux_output_select,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic Feature_we,
  output logic Output_we,
  output logic [$clog2(FEATURE_BEATS+1)-1:0] mux_next_feature_we_select,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] mux9_select,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] KERNEL_read_addr,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] KERNEL_write_addr,
  output logic KERNEL_re,
  output logic product_valid,
  output logic mac_valid,
  output logic mac_accumulate_internal,
  output logic [$clog2(NB_KERNEL_BANKS+1)-1:0] mux_KERNEL_we_select
);

  localparam int OB   = output_beats(OUTPUT_NB_CHANNELS, OUTS_PER_BEAT);
  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int XW   = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW   = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW   = $clog2(OUTPUT_NB_CHANNELS);
  localparam int OSW  = $clog2(OB);
  localparam int OBW  = $clog2(OB + 1);
  localparam int FSW  = $clog2(FEATURE_BEATS + 1);
  localparam int AW   = $clog2(TAPS);
  localparam int TW   = $clog2(TAPS + 2);
  localparam int BSW  = $clog2(NB_KERNEL_BANKS + 1);

  state_e         state_q, state_d;
  logic [2:0]     stride_q, stride_d;
  logic [XW-1:0]  x_q, x_d, out_x_q, out_x_d, next_x;
  logic [YW-1:0]  y_q, y_d, out_y_q, out_y_d, next_y;
  logic           first_q, first_d, cfg_err_q, cfg_err_d;
  logic           last_x, last_y, last_tile, cnt_clr;
  logic           kaddr_en, kbank_en, feat_en, tap_en, ob_en;
  logic           kaddr_last, kbank_last, feat_last, tap_last, ob_last;
  logic           tap_done, feat_done, out_done;
  logic [AW-1:0]  kaddr;
  logic [BSW-1:0] kbank;
  logic [FSW-1:0] feat;
  logic [TW-1:0]  tap;
  logic [OBW-1:0] ob;

  wrap_counter #(.WIDTH(AW),  .MAX(TAPS - 1))            u_kaddr (.clk(clk), .arst_n_in(arst_n_in), .en(kaddr_en), .clr(cnt_clr), .count(kaddr), .last(kaddr_last));
  wrap_counter #(.WIDTH(BSW), .MAX(NB_KERNEL_BANKS - 1)) u_kbank (.clk(clk), .arst_n_in(arst_n_in), .en(kbank_en), .clr(cnt_clr), .count(kbank), .last(kbank_last));
  wrap_counter #(.WIDTH(FSW), .MAX(FEATURE_BEATS))       u_feat  (.clk(clk), .arst_n_in(arst_n_in), .en(feat_en),  .clr(cnt_clr), .count(feat),  .last(feat_last));
  wrap_counter #(.WIDTH(TW),  .MAX(TAPS + 1))            u_tap   (.clk(clk), .arst_n_in(arst_n_in), .en(tap_en),   .clr(cnt_clr), .count(tap),   .last(tap_last));
  wrap_counter #(.WIDTH(OBW), .MAX(OB))                  u_ob    (.clk(clk), .arst_n_in(arst_n_in), .en(ob_en),    .clr(cnt_clr), .count(ob),    .last(ob_last));

  // Every state change restarts the counters, so each phase starts from zero.
  assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);

  assign last_x    = (int'(x_q) + int'(stride_q)) >= FEATURE_MAP_WIDTH;
  assign last_y    = (int'(y_q) + int'(stride_q)) >= FEATURE_MAP_HEIGHT;
  assign last_tile = last_x && last_y;
  assign next_y    = last_y ? '0 : YW'(int'(y_q) + int'(stride_q));
  assign next_x    = !last_y ? x_q : (last_x ? '0 : XW'(int'(x_q) + int'(stride_q)));

  // The tap counter parks at TAPS+1 so the mac cycle (TAPS) fires only once.
  assign tap_done  = (int'(tap) >= TAPS);
  assign feat_done = last_tile || feat_last;
  assign out_done  = first_q || ob_last;

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    x_d        = x_q;
    y_d        = y_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    first_d    = first_q;
    cfg_err_d  = 1'b0;
    kaddr_en   = 1'b0;
    kbank_en   = 1'b0;
    feat_en    = 1'b0;
    tap_en     = 1'b0;
    ob_en      = 1'b0;
    bus_ready  = 1'b0;
    output_valid = 1'b0;
    Feature_we = 1'b0;
    Output_we  = 1'b0;
    KERNEL_re  = 1'b0;
    product_valid = 1'b0;
    mac_valid  = 1'b0;
    mac_accumulate_internal = 1'b1;
    KERNEL_read_addr  = '0;
    KERNEL_write_addr = '0;
    mux_output_select = '0;
    output_ch  = '0;
    mux_next_feature_we_select = FSW'(FEATURE_BEATS);
    mux_KERNEL_we_select       = BSW'(NB_KERNEL_BANKS);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (conv_stride_mode == MODE_RESERVED) begin
            cfg_err_d = 1'b1;
          end else begin
            stride_d = stride_of(conv_stride_mode);
            x_d      = '0;
            y_d      = '0;
            first_d  = 1'b1;
            state_d  = ST_LOAD_KERNEL;
          end
        end
      end
      ST_LOAD_KERNEL: begin
        bus_ready         = 1'b1;
        KERNEL_write_addr = kaddr;
        if (bus_valid) begin
          mux_KERNEL_we_select = kbank;
          kaddr_en = 1'b1;
          kbank_en = kaddr_last;
          if (kaddr_last && kbank_last) state_d = ST_LOAD_FEATURE;
        end
      end
      ST_LOAD_FEATURE: begin
        bus_ready = 1'b1;
        if (bus_valid) begin
          mux_next_feature_we_select = feat;
          feat_en = 1'b1;
          if (feat == FSW'(FEATURE_BEATS - 1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        Feature_we = 1'b1;
        Output_we  = !first_q;
        if (!first_q) begin
          out_x_d = x_q;
          out_y_d = y_q;
          x_d     = next_x;
          y_d     = next_y;
        end
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        tap_en = !tap_last;
        if (int'(tap) < TAPS) begin
          product_valid    = 1'b1;
          KERNEL_re        = 1'b1;
          KERNEL_read_addr = AW'(tap);
        end
        if (tap != '0 && int'(tap) <= TAPS) begin
          mac_valid = 1'b1;
          mac_accumulate_internal = (tap != TW'(1));
        end
        if (!feat_done) begin
          bus_ready = 1'b1;
          if (bus_valid) begin
            mux_next_feature_we_select = feat;
            feat_en = 1'b1;
          end
        end
        if (!out_done) begin
          output_valid      = 1'b1;
          mux_output_select = OSW'(ob);
          output_ch         = CW'(int'(ob) * OUTS_PER_BEAT);
          ob_en             = output_ready;
        end
        if (tap_done && feat_done && out_done) begin
          if (last_tile) begin
            // The final tile has no following COMMIT, so its results are written here.
            Output_we = 1'b1;
            out_x_d   = x_q;
            out_y_d   = y_q;
            state_d   = ST_DRAIN;
          end else begin
            first_d = 1'b0;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_DRAIN: begin
        output_valid      = 1'b1;
        mux_output_select = OSW'(ob);
        output_ch         = CW'(int'(ob) * OUTS_PER_BEAT);
        ob_en             = output_ready;
        if (output_ready && ob == OBW'(OB - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  assign mux9_select    = KERNEL_read_addr;
  assign driving_busses = output_valid;
  assign running        = (state_q != ST_IDLE);
  assign cfg_error      = cfg_err_q;
  assign output_x       = out_x_q;
  assign output_y       = out_y_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q   <= ST_IDLE;
      stride_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      first_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      x_q       <= x_d;
      y_q       <= y_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      first_q   <= first_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_param_conv_controller.sv
// Directed bench for param_conv_controller on a small 4x4 map, K=3, 2 banks.
module tb_param_conv_controller;

  localparam int W = 4, H = 4, CH = 8, K = 3, NB = 2, FB = 2, OPB = 3;
  localparam logic [10:0] STROBE_IDLE = 11'b000_0000_0001;
  localparam logic [20:0] SEL_IDLE    = {2'd2, 2'd2, 2'd0, 4'd0, 4'd0, 4'd0, 3'd0};

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  logic start = 1'b0, abort = 1'b0, bus_valid = 1'b0, output_ready = 1'b0;
  logic [1:0] conv_stride_mode = 2'd0;
  logic running, cfg_error, bus_ready, output_valid, driving_busses;
  logic Feature_we, Output_we, KERNEL_re, product_valid, mac_valid, mac_accumulate_internal;
  logic [1:0] mux_output_select, output_x, output_y, mux_next_feature_we_select, mux_KERNEL_we_select;
  logic [2:0] output_ch;
  logic [3:0] mux9_select, KERNEL_read_addr, KERNEL_write_addr;
  logic [10:0] strobes;
  logic [20:0] sels;

  param_conv_controller #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(CH),
    .KERNEL_SIZE(K), .NB_KERNEL_BANKS(NB), .FEATURE_BEATS(FB), .OUTS_PER_BEAT(OPB)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .abort(abort),
    .conv_stride_mode(conv_stride_mode), .running(running), .cfg_error(cfg_error),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .output_valid(output_valid),
    .output_ready(output_ready), .driving_busses(driving_busses),
    .mux_output_select(mux_output_select), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch), .Feature_we(Feature_we), .Output_we(Output_we),
    .mux_next_feature_we_select(mux_next_feature_we_select), .mux9_select(mux9_select),
    .KERNEL_read_addr(KERNEL_read_addr), .KERNEL_write_addr(KERNEL_write_addr),
    .KERNEL_re(KERNEL_re), .product_valid(product_valid), .mac_valid(mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal), .mux_KERNEL_we_select(mux_KERNEL_we_select)
  );

  always #5 clk = ~clk;

  assign strobes = {running, cfg_error, bus_ready, output_valid, driving_busses, Feature_we,
                    Output_we, KERNEL_re, product_valid, mac_valid, mac_accumulate_internal};
  assign sels = {mux_next_feature_we_select, mux_KERNEL_we_select, mux_output_select,
                 mux9_select, KERNEL_read_addr, KERNEL_write_addr, output_ch};

  int total_cnt = 0, pass_cnt = 0;
  int n_bus, n_beats, n_fwe, n_owe, n_mac, n_prod, n_acc0, n_acc_bad;
  int qx[$], qy[$], qs[$], qc[$];

  task automatic clear_stats();
    n_bus = 0; n_beats = 0; n_fwe = 0; n_owe = 0;
    n_mac = 0; n_prod = 0; n_acc0 = 0; n_acc_bad = 0;
    qx.delete(); qy.delete(); qs.delete(); qc.delete();
  endtask

  // Inputs for the current cycle are already driven; record what the next edge will see.
  task automatic sample();
    #1;
    if (bus_valid && bus_ready) n_bus++;
    if (output_valid && output_ready) begin
      n_beats++;
      qx.push_back(int'(output_x)); qy.push_back(int'(output_y));
      qs.push_back(int'(mux_output_select)); qc.push_back(int'(output_ch));
    end
    if (Feature_we) n_fwe++;
    if (Feature_we && Output_we) n_owe++;
    if (mac_valid) n_mac++;
    if (product_valid) n_prod++;
    if (mac_valid && !mac_accumulate_internal) n_acc0++;
    if (!mac_valid && !mac_accumulate_internal) n_acc_bad++;
  endtask

  task automatic start_job(input logic [1:0] mode);
    @(negedge clk);
    start = 1'b1; conv_stride_mode = mode; bus_valid = 1'b0; output_ready = 1'b1; abort = 1'b0;
    sample();
  endtask

  task automatic run_to_idle(input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0; bus_valid = 1'b1; output_ready = 1'b1;
      sample();
      if (!running) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (strobes !== STROBE_IDLE) $display("FAIL reset_strobes got %b want %b", strobes, STROBE_IDLE);
    else pass_cnt++;
    total_cnt++;
    if (sels !== SEL_IDLE) $display("FAIL reset_selects got %h want %h", sels, SEL_IDLE);
    else pass_cnt++;
    total_cnt++;
    if ({output_x, output_y} !== 4'd0) $display("FAIL reset_xy got %h want 0", {output_x, output_y});
    else pass_cnt++;
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (strobes !== STROBE_IDLE) $display("FAIL post_reset_idle got %b want %b", strobes, STROBE_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_cfg_error();
    @(negedge clk);
    start = 1'b1; conv_stride_mode = 2'd3;
    #1;
    total_cnt++;
    if ({cfg_error, running} !== 2'b00) $display("FAIL cfg_err_pre got %b want 00", {cfg_error, running});
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    #1;
    total_cnt++;
    if ({cfg_error, running} !== 2'b10) $display("FAIL cfg_err_pulse got %b want 10", {cfg_error, running});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({cfg_error, running} !== 2'b00) $display("FAIL cfg_err_end got %b want 00", {cfg_error, running});
    else pass_cnt++;
  endtask

  task automatic test_kernel_load();
    int writes = 0;
    @(negedge clk);
    start = 1'b1; conv_stride_mode = 2'd1; bus_valid = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      start = 1'b0;
      bus_valid = (i % 2 == 0);
      #1;
      if (mux_KERNEL_we_select != 2'd2) writes++;
      total_cnt++;
      if (bus_valid) begin
        if ({bus_ready, mux_KERNEL_we_select, KERNEL_write_addr} !== {1'b1, 2'((i / 2) / 9), 4'((i / 2) % 9)})
          $display("FAIL kernel_beat%0d got rdy=%b bank=%0d addr=%0d want bank=%0d addr=%0d", i / 2,
                   bus_ready, mux_KERNEL_we_select, KERNEL_write_addr, (i / 2) / 9, (i / 2) % 9);
        else pass_cnt++;
      end else begin
        if (mux_KERNEL_we_select !== 2'd2) $display("FAIL kernel_gap%0d got bank=%0d want 2", i, mux_KERNEL_we_select);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (writes != 18) $display("FAIL kernel_writes got %0d want 18", writes);
    else pass_cnt++;
    @(negedge clk);
    bus_valid = 1'b1;
    #1;
    total_cnt++;
    if ({bus_ready, mux_KERNEL_we_select, mux_next_feature_we_select} !== {1'b1, 2'd2, 2'd0})
      $display("FAIL load_feature_entry got %b want 1_10_00", {bus_ready, mux_KERNEL_we_select, mux_next_feature_we_select});
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus_valid = 1'b0;
    #1;
    total_cnt++;
    if (strobes !== STROBE_IDLE) $display("FAIL kernel_abort got %b want %b", strobes, STROBE_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_tile_order();
    bit to;
    clear_stats();
    start_job(2'd1);
    run_to_idle(600, to);
    total_cnt++;
    if (to !== 1'b0) $display("FAIL tile_timeout got 1 want 0");
    else pass_cnt++;
    total_cnt++;
    if (n_beats != 12) $display("FAIL tile_beats got %0d want 12", n_beats);
    else pass_cnt++;
    for (int k = 0; k < qx.size(); k++) begin
      total_cnt++;
      if (qx[k] != ((k / 3) / 2) * 2 || qy[k] != ((k / 3) % 2) * 2 || qs[k] != k % 3 || qc[k] != (k % 3) * 3)
        $display("FAIL tile_beat%0d got x=%0d y=%0d sel=%0d ch=%0d want x=%0d y=%0d sel=%0d ch=%0d", k,
                 qx[k], qy[k], qs[k], qc[k], ((k / 3) / 2) * 2, ((k / 3) % 2) * 2, k % 3, (k % 3) * 3);
      else pass_cnt++;
    end
    total_cnt++;
    if ({n_fwe, n_owe} != {32'd4, 32'd3}) $display("FAIL tile_commits got fwe=%0d owe=%0d want 4 3", n_fwe, n_owe);
    else pass_cnt++;
    total_cnt++;
    if ({n_mac, n_prod, n_acc0, n_acc_bad} != {32'd36, 32'd36, 32'd4, 32'd0})
      $display("FAIL tile_mac got mac=%0d prod=%0d acc0=%0d bad=%0d want 36 36 4 0", n_mac, n_prod, n_acc0, n_acc_bad);
    else pass_cnt++;
    total_cnt++;
    if (n_bus != 26) $display("FAIL tile_bus_beats got %0d want 26", n_bus);
    else pass_cnt++;
  endtask

  task automatic test_stride_extremes();
    bit to;
    clear_stats();
    start_job(2'd0);
    run_to_idle(2000, to);
    total_cnt++;
    if (to !== 1'b0 || n_beats != 48 || n_fwe != 16)
      $display("FAIL stride1_job got to=%0d beats=%0d fwe=%0d want 0 48 16", to, n_beats, n_fwe);
    else pass_cnt++;
    total_cnt++;
    if (qx.size() == 0 || qx[qx.size() - 1] != 3 || qy[qy.size() - 1] != 3)
      $display("FAIL stride1_last_tile got beats=%0d want final (3,3)", qx.size());
    else pass_cnt++;
    clear_stats();
    start_job(2'd2);
    run_to_idle(300, to);
    total_cnt++;
    if (to !== 1'b0 || n_beats != 3 || n_bus != 20 || n_mac != 9)
      $display("FAIL stride4_job got to=%0d beats=%0d bus=%0d mac=%0d want 0 3 20 9", to, n_beats, n_bus, n_mac);
    else pass_cnt++;
    for (int k = 0; k < qx.size(); k++) begin
      total_cnt++;
      if (qx[k] != 0 || qy[k] != 0 || qs[k] != k || qc[k] != k * 3)
        $display("FAIL stride4_beat%0d got x=%0d y=%0d sel=%0d ch=%0d want 0 0 %0d %0d", k, qx[k], qy[k], qs[k], qc[k], k, k * 3);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit found = 1'b0;
    logic [8:0] p;
    clear_stats();
    start_job(2'd1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0; bus_valid = 1'b1; output_ready = 1'b0;
      sample();
      if (output_valid) begin
        found = 1'b1;
        break;
      end
    end
    p = {output_x, output_y, mux_output_select, output_ch};
    total_cnt++;
    if (!found || p !== 9'd0) $display("FAIL stall_first_beat got found=%0d payload=%h want 1 000", found, p);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      output_ready = 1'b0;
      sample();
      total_cnt++;
      if ({output_valid, Feature_we, output_x, output_y, mux_output_select, output_ch} !== {2'b10, p})
        $display("FAIL stall_cycle%0d got v=%b fwe=%b payload=%h want 1 0 %h", c, output_valid, Feature_we,
                 {output_x, output_y, mux_output_select, output_ch}, p);
      else pass_cnt++;
    end
    run_to_idle(600, to);
    total_cnt++;
    if (to !== 1'b0 || n_beats != 12 || n_fwe != 4)
      $display("FAIL stall_job got to=%0d beats=%0d fwe=%0d want 0 12 4", to, n_beats, n_fwe);
    else pass_cnt++;
    total_cnt++;
    if (qx.size() < 4 || qx[3] != 0 || qy[3] != 2) $display("FAIL stall_order got beats=%0d want beat3 at (0,2)", qx.size());
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit to;
    bit found = 1'b0;
    clear_stats();
    start_job(2'd1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0; bus_valid = 1'b1; output_ready = 1'b1;
      sample();
      if (product_valid && KERNEL_read_addr == 4'd4) begin
        found = 1'b1;
        break;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus_valid = 1'b0;
    #1;
    total_cnt++;
    if (!found || strobes !== STROBE_IDLE || sels !== SEL_IDLE)
      $display("FAIL abort_idle got found=%0d strobes=%b sels=%h want 1 %b %h", found, strobes, sels, STROBE_IDLE, SEL_IDLE);
    else pass_cnt++;
    clear_stats();
    start_job(2'd1);
    run_to_idle(600, to);
    total_cnt++;
    if (to !== 1'b0 || n_beats != 12 || n_fwe != 4 || n_mac != 36 || n_bus != 26)
      $display("FAIL abort_rerun got to=%0d beats=%0d fwe=%0d mac=%0d bus=%0d want 0 12 4 36 26", to, n_beats, n_fwe, n_mac, n_bus);
    else pass_cnt++;
    total_cnt++;
    if (qx.size() != 12 || qx[11] != 2 || qy[11] != 2) $display("FAIL abort_rerun_last got beats=%0d want final (2,2)", qx.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_drain();
    bit found = 1'b0;
    clear_stats();
    start_job(2'd1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0; bus_valid = 1'b1; output_ready = 1'b1;
      sample();
      if (output_valid && output_x == 2'd2 && output_y == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    output_ready = 1'b0;
    #2 arst_n_in = 1'b0;
    #1;
    total_cnt++;
    if (!found || strobes !== STROBE_IDLE || sels !== SEL_IDLE || {output_x, output_y} !== 4'd0)
      $display("FAIL drain_reset got found=%0d strobes=%b sels=%h xy=%h want 1 %b %h 0", found, strobes, sels,
               {output_x, output_y}, STROBE_IDLE, SEL_IDLE);
    else pass_cnt++;
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (strobes !== STROBE_IDLE) $display("FAIL drain_reset_release got %b want %b", strobes, STROBE_IDLE);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cfg_error();
    test_kernel_load();
    test_tile_order();
    test_stride_extremes();
    test_backpressure();
    test_abort();
    test_reset_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
